// File: rtl/vote_ctrl_param_if.sv
// Downstream result channel: 4-phase RTS/RTR handshake carrying the tally and
// its majority/unanimity flags.
interface vote_ctrl_param_if #(
    parameter int DATA_W = 4
);
    logic              rts;
    logic              rtr;
    logic [DATA_W-1:0] v_out;
    logic              majority;
    logic              unanimous;

    modport master (
        output rts,
        output v_out,
        output majority,
        output unanimous,
        input  rtr
    );

    modport slave (
        input  rts,
        input  v_out,
        input  majority,
        input  unanimous,
        output rtr
    );
endinterface

// File: rtl/vote_ctrl_param.sv
// Voting controller: collects first-press votes from N_BTN buttons under key,
// or forwards v_in in test mode, then ships the result over RTS/RTR.
module vote_ctrl_param #(
    parameter int N_BTN   = 4,
    parameter int DATA_W  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               test,
    input  logic               key,
    input  logic [N_BTN-1:0]   btn,
    input  logic [DATA_W-1:0]  v_in,
    output logic               cts,
    output logic               busy,
    vote_ctrl_param_if.master  dn
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] N_CNT    = DATA_W'(N_BTN);
    localparam logic [DATA_W+1:0] N_EXT    = (DATA_W + 2)'(N_BTN);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        TEST_LOAD,
        SEND,
        WAIT_ACK
    } state_t;

    state_t              state_q,     state_d;
    logic [N_BTN-1:0]    voted_q,     voted_d;
    logic [N_BTN-1:0]    last_btn_q,  last_btn_d;
    logic [CNT_W-1:0]    tmo_cnt_q,   tmo_cnt_d;
    logic [DATA_W-1:0]   v_out_q,     v_out_d;
    logic                majority_q,  majority_d;
    logic                unanimous_q, unanimous_d;
    logic                rts_q,       rts_d;

    logic [N_BTN-1:0]    rise;
    logic [N_BTN-1:0]    vote_next;
    logic [DATA_W-1:0]   cnt;

    function automatic logic [DATA_W-1:0] popcount(input logic [N_BTN-1:0] v);
        logic [DATA_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_BTN; i++) begin
            c = c + DATA_W'(v[i]);
        end
        return c;
    endfunction

    always_comb begin
        state_d     = state_q;
        voted_d     = voted_q;
        last_btn_d  = btn;
        tmo_cnt_d   = tmo_cnt_q;
        v_out_d     = v_out_q;
        majority_d  = majority_q;
        unanimous_d = unanimous_q;

        // Votes landing on the closing cycle must be included in the tally.
        rise      = btn & ~last_btn_q;
        vote_next = key ? (voted_q | rise) : voted_q;
        cnt       = popcount(vote_next);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (test) begin
                        state_d = TEST_LOAD;
                    end else begin
                        state_d   = COLLECT;
                        voted_d   = '0;
                        tmo_cnt_d = '0;
                    end
                end
            end
            COLLECT: begin
                voted_d   = vote_next;
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if ((&vote_next) || (tmo_cnt_q == TMO_LAST)) begin
                    state_d     = SEND;
                    v_out_d     = cnt;
                    majority_d  = ({1'b0, cnt, 1'b0} > N_EXT);
                    unanimous_d = (cnt == N_CNT);
                end
            end
            TEST_LOAD: begin
                state_d     = SEND;
                v_out_d     = v_in;
                majority_d  = 1'b0;
                unanimous_d = 1'b0;
            end
            SEND: begin
                // Leave only after rts has been visible for at least one cycle.
                if (rts_q && dn.rtr) begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!dn.rtr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        rts_d = (state_q == SEND) && !(rts_q && dn.rtr);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            voted_q     <= '0;
            last_btn_q  <= '0;
            tmo_cnt_q   <= '0;
            v_out_q     <= '0;
            majority_q  <= 1'b0;
            unanimous_q <= 1'b0;
            rts_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            voted_q     <= voted_d;
            last_btn_q  <= last_btn_d;
            tmo_cnt_q   <= tmo_cnt_d;
            v_out_q     <= v_out_d;
            majority_q  <= majority_d;
            unanimous_q <= unanimous_d;
            rts_q       <= rts_d;
        end
    end

    assign cts          = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign dn.rts       = rts_q;
    assign dn.v_out     = v_out_q;
    assign dn.majority  = majority_q;
    assign dn.unanimous = unanimous_q;

endmodule
